// File: rtl/y86_dmem_stage.sv
// Y86-64 data-memory stage: request/response handshake, wait states,
// bounds/alignment checking and registered read data.
module y86_dmem_stage #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter bit ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valA,
  input  logic [ADDR_W-1:0] valE,
  input  logic [ADDR_W-1:0] valP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valM,
  output logic              mem_error,
  output logic [DATA_W-1:0] dbg_word
);
  localparam int WB  = DATA_W / 8;
  localparam int OFF = $clog2(WB);
  localparam int IW  = $clog2(DEPTH);
  localparam bit NOWAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT0 =
    NOWAIT ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(longint'(DEPTH) * longint'(WB));
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(WB - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE, OP_RD, OP_WR
  } op_t;

  state_t state, state_n;
  logic [3:0] cnt;

  op_t               in_op, l_op, acc_op;
  logic [ADDR_W-1:0] in_addr, l_addr, acc_addr;
  logic [DATA_W-1:0] in_data, l_data, acc_data;

  logic          accept, fire, bad, is_mem, we;
  logic [IW-1:0] idx;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    in_op   = OP_NONE;
    in_addr = valE;
    in_data = DATA_W'(valA);
    unique case (icode)
      4'h4, 4'hA: in_op = OP_WR;
      4'h5:       in_op = OP_RD;
      4'h8: begin
        in_op   = OP_WR;
        in_data = DATA_W'(valP);
      end
      4'h9, 4'hB: begin
        in_op   = OP_RD;
        in_addr = valA;
      end
      default: in_op = OP_NONE;
    endcase
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_n = NOWAIT ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd0)
          state_n = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Zero-wait configs access straight from the ports on the accept edge.
  assign acc_op   = (state == S_IDLE) ? in_op   : l_op;
  assign acc_addr = (state == S_IDLE) ? in_addr : l_addr;
  assign acc_data = (state == S_IDLE) ? in_data : l_data;

  assign fire = (state == S_IDLE) ? (accept && NOWAIT)
              : (state == S_WAIT && cnt == 4'd0);

  assign bad = ({1'b0, acc_addr} >= LIMIT) ||
               (ALIGN_CHECK && ((acc_addr & MASK) != '0));

  assign idx    = acc_addr[IW+OFF-1:OFF];
  assign is_mem = (acc_op != OP_NONE);
  assign we     = fire && (acc_op == OP_WR) && !bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      l_op   <= OP_NONE;
      l_addr <= '0;
      l_data <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && accept) begin
        l_op   <= in_op;
        l_addr <= in_addr;
        l_data <= in_data;
        cnt    <= CNT0;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= acc_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valM      <= '0;
      mem_error <= 1'b0;
      dbg_word  <= '0;
    end else if (fire) begin
      valM      <= (acc_op == OP_RD && !bad) ? mem[idx] : '0;
      mem_error <= is_mem && bad;
      if (is_mem && !bad)
        dbg_word <= (acc_op == OP_WR) ? acc_data : mem[idx];
    end
  end

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Randomised + directed bench for y86_dmem_stage against a
// transaction-level memory model (three parameter sets).
module tb_y86_dmem_stage;
  localparam int D0 = 1024;
  localparam int D2 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, rv_a, rv_b;
  logic [3:0]  ic_a, ic_b;
  logic [63:0] a_a, e_a, p_a, a_b, e_b, p_b;

  logic        d_rdy [3];
  logic        d_rv  [3];
  logic        d_err [3];
  logic [63:0] d_vm  [3];
  logic [63:0] d_dbg [3];

  y86_dmem_stage u0 (
    .clk(clk), .rst(rst_a), .req_valid(rv_a),
    .req_ready(d_rdy[0]), .icode(ic_a),
    .valA(a_a), .valE(e_a), .valP(p_a),
    .resp_valid(d_rv[0]), .valM(d_vm[0]),
    .mem_error(d_err[0]), .dbg_word(d_dbg[0])
  );

  y86_dmem_stage #(.ALIGN_CHECK(0)) u1 (
    .clk(clk), .rst(rst_a), .req_valid(rv_a),
    .req_ready(d_rdy[1]), .icode(ic_a),
    .valA(a_a), .valE(e_a), .valP(p_a),
    .resp_valid(d_rv[1]), .valM(d_vm[1]),
    .mem_error(d_err[1]), .dbg_word(d_dbg[1])
  );

  y86_dmem_stage #(.WAIT_STATES(3), .DEPTH(D2)) u2 (
    .clk(clk), .rst(rst_b), .req_valid(rv_b),
    .req_ready(d_rdy[2]), .icode(ic_b),
    .valA(a_b), .valE(e_b), .valP(p_b),
    .resp_valid(d_rv[2]), .valM(d_vm[2]),
    .mem_error(d_err[2]), .dbg_word(d_dbg[2])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int wst [3] = '{0, 0, 3};
  int dep [3] = '{D0, D0, D2};
  bit aln [3] = '{1'b1, 1'b0, 1'b1};

  logic [63:0] mm [3][1024];
  int          acc [3] = '{-100, -100, -100};
  logic [63:0] vm_p [3], vm_n [3];
  logic [63:0] db_p [3], db_n [3];
  bit          er_p [3], er_n [3];

  bit rdy_h [int];
  bit rv_h  [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pf(int i);
    return 64'h1111_0000_0000_0000 + 64'(i) * 64'h101;
  endfunction

  // Transaction-level effect of one request on the model memory.
  function automatic void model(
    int c, logic [3:0] ic, logic [63:0] va, logic [63:0] ve,
    logic [63:0] vp, logic [63:0] db_old,
    output logic [63:0] vm, output bit er,
    output logic [63:0] db);
    bit wr, rd;
    logic [63:0] ad, wd;
    longint unsigned ix;
    wr = ic inside {4'h4, 4'h8, 4'hA};
    rd = ic inside {4'h5, 4'h9, 4'hB};
    ad = (ic == 4'h9 || ic == 4'hB) ? va : ve;
    wd = (ic == 4'h8) ? vp : va;
    vm = '0;
    er = 1'b0;
    db = db_old;
    if (!(wr || rd)) return;
    if (ad >= 64'(dep[c]) * 8 || (aln[c] && ad % 8 != 0)) begin
      er = 1'b1;
      return;
    end
    ix = ad / 8;
    if (wr) begin
      mm[c][ix] = wd;
      db = wd;
    end else begin
      vm = mm[c][ix];
      db = vm;
    end
  endfunction

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      bit busy, shown;
      busy  = cyc >= acc[c] && cyc <= acc[c] + wst[c];
      shown = cyc >= acc[c] + wst[c];
      chk($sformatf("ch%0d req_ready @%0d", c, cyc),
          64'(d_rdy[c]), 64'(!busy));
      chk($sformatf("ch%0d resp_valid @%0d", c, cyc),
          64'(d_rv[c]), 64'(cyc == acc[c] + wst[c]));
      chk($sformatf("ch%0d valM @%0d", c, cyc),
          d_vm[c], shown ? vm_n[c] : vm_p[c]);
      chk($sformatf("ch%0d mem_error @%0d", c, cyc),
          64'(d_err[c]), 64'(shown ? er_n[c] : er_p[c]));
      chk($sformatf("ch%0d dbg_word @%0d", c, cyc),
          d_dbg[c], shown ? db_n[c] : db_p[c]);
    end
    rdy_h[cyc] = d_rdy[2];
    rv_h[cyc]  = d_rv[2];
  end

  task automatic drive(int g, logic v, logic [3:0] ic,
                       logic [63:0] a, logic [63:0] e,
                       logic [63:0] p);
    if (g == 0) begin
      rv_a = v; ic_a = ic; a_a = a; e_a = e; p_a = p;
    end else begin
      rv_b = v; ic_b = ic; a_b = a; e_b = e; p_b = p;
    end
  endtask

  task automatic model_reset(int g);
    int lo = (g == 0) ? 0 : 2;
    int hi = (g == 0) ? 1 : 2;
    for (int c = lo; c <= hi; c++) begin
      acc[c] = -100;
      vm_p[c] = '0; vm_n[c] = '0;
      db_p[c] = '0; db_n[c] = '0;
      er_p[c] = 1'b0; er_n[c] = 1'b0;
    end
  endtask

  // Present a request while idle; garbage (or the same request when
  // keep=1) is driven during the busy cycles and must be ignored.
  task automatic issue(int g, logic [3:0] ic, logic [63:0] a,
                       logic [63:0] e, logic [63:0] p, bit keep);
    int w  = (g == 0) ? 0 : 3;
    int lo = (g == 0) ? 0 : 2;
    int hi = (g == 0) ? 1 : 2;
    drive(g, 1'b1, ic, a, e, p);
    @(posedge clk);
    #1;
    for (int c = lo; c <= hi; c++) begin
      logic [63:0] vm, db;
      bit er;
      model(c, ic, a, e, p, db_n[c], vm, er, db);
      vm_p[c] = vm_n[c]; er_p[c] = er_n[c]; db_p[c] = db_n[c];
      vm_n[c] = vm; er_n[c] = er; db_n[c] = db;
      acc[c] = cyc;
    end
    for (int i = 0; i <= w; i++) begin
      if (keep)
        drive(g, 1'b1, ic, a, e, p);
      else
        drive(g, 1'($urandom % 2), 4'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom});
      @(posedge clk);
      #1;
    end
    drive(g, 1'b0, 4'h0, '0, '0, '0);
  endtask

  function automatic logic [63:0] raddr(int d);
    int k;
    k = $urandom_range(0, 9);
    if (k <= 5) return 64'($urandom_range(0, d - 1)) * 8;
    if (k <= 7) return 64'($urandom_range(0, d * 8 - 1));
    if (k == 8) return 64'(d * 8) + 64'($urandom_range(0, 64));
    return {$urandom, $urandom};
  endfunction

  task automatic rand_txn(int g, int d);
    logic [3:0] ops [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    logic [3:0] ic;
    logic [63:0] a;
    ic = ($urandom % 8 < 7) ? ops[$urandom % 6] : 4'($urandom);
    a  = ($urandom % 2 == 1) ? raddr(d) : {$urandom, $urandom};
    issue(g, ic, a, raddr(d), {$urandom, $urandom},
          1'($urandom % 2));
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 4'h0, '0, '0, '0);
    drive(1, 1'b0, 4'h0, '0, '0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      begin
        for (int i = 0; i < D0; i++)
          issue(0, 4'h4, pf(i), 64'(i * 8), '0, 1'b0);
        issue(0, 4'hA, 64'hDEADBEEFCAFEF00D, 64'h100, '0, 1'b0);
        issue(0, 4'hB, 64'h100, '0, '0, 1'b0);
        chk("t1 popq valM", d_vm[0], 64'hDEADBEEFCAFEF00D);
        chk("t1 popq err", 64'(d_err[0]), 64'd0);
        issue(0, 4'h8, '0, 64'h1F8, 64'h42, 1'b0);
        issue(0, 4'h9, 64'h1F8, '0, '0, 1'b0);
        chk("t2 ret valM", d_vm[0], 64'h42);
        issue(0, 4'h4, 64'd7, 64'h1F8, '0, 1'b0);
        issue(0, 4'h5, '0, 64'h1F8, '0, 1'b0);
        chk("t2 mrmovq valM", d_vm[0], 64'd7);
        issue(0, 4'h5, '0, 64'h2000, '0, 1'b0);
        chk("t3 oob err", 64'(d_err[0]), 64'd1);
        chk("t3 oob valM", d_vm[0], 64'd0);
        issue(0, 4'h4, 64'hBAD, 64'h2000, '0, 1'b0);
        issue(0, 4'h5, '0, 64'h0, '0, 1'b0);
        chk("t3 word0 intact", d_vm[0], 64'h1111_0000_0000_0000);
        issue(0, 4'h5, '0, 64'h104, '0, 1'b0);
        chk("t3 misalign err", 64'(d_err[0]), 64'd1);
        chk("t3 noalign err", 64'(d_err[1]), 64'd0);
        chk("t3 noalign valM", d_vm[1], 64'hDEADBEEFCAFEF00D);
        issue(0, 4'h0, 64'h1FF8, '1, '1, 1'b0);
        chk("t6 halt err", 64'(d_err[0]), 64'd0);
        chk("t6 halt valM", d_vm[0], 64'd0);
        issue(0, 4'h6, 64'h1FF8, '1, '1, 1'b0);
        chk("t6 opq err", 64'(d_err[0]), 64'd0);
        issue(0, 4'h5, '0, 64'h1FF8, '0, 1'b0);
        chk("t6 word1023", d_vm[0], 64'h1111_0000_0004_02FF);
        for (int i = 0; i < 300; i++)
          rand_txn(0, D0);
      end
      begin
        int a0, a1;
        for (int i = 0; i < D2; i++)
          issue(1, 4'h4, pf(i), 64'(i * 8), '0, 1'b0);
        issue(1, 4'h5, '0, 64'h10, '0, 1'b1);
        a0 = acc[2];
        issue(1, 4'h5, '0, 64'h10, '0, 1'b1);
        a1 = acc[2];
        chk("t4 accept spacing", 64'(a1 - a0), 64'd5);
        chk("t4 valM", d_vm[2], 64'h1111_0000_0000_0202);
        for (int i = 0; i <= 4; i++) begin
          chk($sformatf("t4 ready +%0d", i),
              64'(rdy_h[a0 + i]), 64'(i == 4));
          chk($sformatf("t4 resp +%0d", i),
              64'(rv_h[a0 + i]), 64'(i == 3));
        end
        issue(1, 4'h4, 64'd9, 64'h10, '0, 1'b0);
        issue(1, 4'h5, '0, 64'h10, '0, 1'b0);
        chk("t5 pre valM", d_vm[2], 64'd9);
        drive(1, 1'b1, 4'h4, 64'd5, 64'h10, '0);
        @(posedge clk);
        #1;
        acc[2] = cyc;
        vm_p[2] = vm_n[2]; er_p[2] = er_n[2]; db_p[2] = db_n[2];
        drive(1, 1'b0, 4'h0, '0, '0, '0);
        @(posedge clk);
        #2;
        model_reset(1);
        rst_b = 1'b1;
        #1;
        chk("t5 rst ready", 64'(d_rdy[2]), 64'd1);
        chk("t5 rst resp", 64'(d_rv[2]), 64'd0);
        chk("t5 rst valM", d_vm[2], 64'd0);
        chk("t5 rst err", 64'(d_err[2]), 64'd0);
        chk("t5 rst dbg", d_dbg[2], 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        issue(1, 4'h5, '0, 64'h10, '0, 1'b0);
        chk("t5 aborted write", d_vm[2], 64'd9);
        for (int i = 0; i < 120; i++)
          rand_txn(1, D2);
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

endmodule
